// File: rtl/tow_pkg.sv
// Shared types and helpers for the tug-of-war match controller.
// Holds the state encoding, the rope-position width and the LED index helper.
package tow_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_ARMED = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int POS_W = 4;

  // Rope marker bit: centre sits at index win_steps, pos shifts it either way.
  function automatic int led_idx(input int win_steps, input logic signed [POS_W-1:0] p);
    return win_steps + int'(p);
  endfunction

endpackage

// File: rtl/tow_pos_decode.sv
// Combinational signed rope position to one-hot LED marker decoder.
module tow_pos_decode
  import tow_pkg::*;
#(
  parameter int WIN_STEPS = 4
) (
  input  logic signed [POS_W-1:0] i_pos,
  output logic [2*WIN_STEPS:0]    o_led
);

  for (genvar g = 0; g <= 2*WIN_STEPS; g++) begin : g_bit
    assign o_led[g] = (led_idx(WIN_STEPS, i_pos) == g);
  end

endmodule

// File: rtl/tow_match_ctrl.sv
// Match-level tug-of-war controller: sequences clear/arm per round, consumes
// the round-result pulse, moves the rope and declares the match winner.
module tow_match_ctrl
  import tow_pkg::*;
#(
  parameter int WIN_STEPS = 4,
  parameter int ARM_DELAY = 16,
  parameter int RND_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    winrnd,
  input  logic                    right,
  input  logic                    tie,
  output logic                    clr,
  output logic                    armed,
  output logic signed [POS_W-1:0] pos,
  output logic [2*WIN_STEPS:0]    led,
  output logic [RND_W-1:0]        rounds,
  output logic                    game_over,
  output logic                    winner_right
);

  localparam int LED_W = 2*WIN_STEPS + 1;
  localparam int CNT_W = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;
  localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(ARM_DELAY - 1);
  localparam logic signed [POS_W-1:0] P_LIM    = POS_W'(WIN_STEPS);
  localparam logic signed [POS_W-1:0] P_ONE    = POS_W'(1);
  localparam logic [RND_W-1:0]        RND_MAX  = '1;
  localparam logic [LED_W-1:0]        LED_CTR  = LED_W'(1) << WIN_STEPS;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic signed [POS_W-1:0] r_pos, w_pos_nxt;
  logic [RND_W-1:0]       r_rounds, w_rounds_nxt;
  logic                   r_win, w_win_nxt;
  logic [LED_W-1:0]       r_led, w_led_nxt;

  // LED is decoded from the next position so it updates on the same edge as pos.
  tow_pos_decode #(.WIN_STEPS(WIN_STEPS)) u_dec (
    .i_pos (w_pos_nxt),
    .o_led (w_led_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pos    <= '0;
      r_rounds <= '0;
      r_win    <= 1'b0;
      r_led    <= LED_CTR;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pos    <= w_pos_nxt;
      r_rounds <= w_rounds_nxt;
      r_win    <= w_win_nxt;
      r_led    <= w_led_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_pos_nxt    = r_pos;
    w_rounds_nxt = r_rounds;
    w_win_nxt    = r_win;
    // A start pulse overrides everything, including a colliding round result.
    if (start) begin
      w_state_nxt  = S_DELAY;
      w_cnt_nxt    = CNT_LOAD;
      w_pos_nxt    = '0;
      w_rounds_nxt = '0;
      w_win_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_DELAY: begin
          if (r_cnt == '0) w_state_nxt = S_ARMED;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        S_ARMED: begin
          if (winrnd) begin
            if (r_rounds != RND_MAX) w_rounds_nxt = r_rounds + 1'b1;
            if (!tie) w_pos_nxt = right ? (r_pos + P_ONE) : (r_pos - P_ONE);
            if (w_pos_nxt == P_LIM || w_pos_nxt == -P_LIM) begin
              w_state_nxt = S_OVER;
              w_win_nxt   = (w_pos_nxt == P_LIM);
            end else begin
              w_state_nxt = S_DELAY;
              w_cnt_nxt   = CNT_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign clr          = (r_state != S_ARMED);
  assign armed        = (r_state == S_ARMED);
  assign game_over    = (r_state == S_OVER);
  assign pos          = r_pos;
  assign led          = r_led;
  assign rounds       = r_rounds;
  assign winner_right = r_win;

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Scoreboard bench for tow_match_ctrl: a driver plays rounds against a
// rope/score model, a monitor checks every round end (armed falling).
module tb_tow_match_ctrl;
  localparam int WS = 2;
  localparam int AD = 3;
  localparam int RW = 8;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, winrnd = 1'b0, right = 1'b0, tie = 1'b0;
  logic clr, armed, game_over, winner_right;
  logic signed [3:0] pos;
  logic [2*WS:0] led;
  logic [RW-1:0] rounds;

  tow_match_ctrl #(.WIN_STEPS(WS), .ARM_DELAY(AD), .RND_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .winrnd(winrnd), .right(right), .tie(tie),
    .clr(clr), .armed(armed), .pos(pos), .led(led), .rounds(rounds),
    .game_over(game_over), .winner_right(winner_right)
  );

  always #5 clk = ~clk;

  typedef struct { int pos; int rounds; bit go; bit wr; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int m_pos = 0, m_rounds = 0;
  bit m_over = 0, m_wr = 0;

  function automatic void chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int exp_led(int p);
    return 1 << (WS + p);
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.pos = m_pos; e.rounds = m_rounds; e.go = m_over; e.wr = m_wr;
    q.push_back(e);
  endfunction

  function automatic void model_reset();
    m_pos = 0; m_rounds = 0; m_over = 0; m_wr = 0;
  endfunction

  // Monitor: every armed 1->0 transition is a round outcome to be scored.
  bit prev_armed = 0;
  exp_t me;
  always @(negedge clk) begin
    if (prev_armed && !armed) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_round_end actual=armed_fell expected=no_event at %0t", $time);
      end else begin
        me = q.pop_front();
        chk("mon_pos", int'(pos), me.pos);
        chk("mon_rounds", int'(rounds), me.rounds);
        chk("mon_led", int'(led), exp_led(me.pos));
        chk("mon_game_over", int'(game_over), int'(me.go));
        chk("mon_clr", int'(clr), 1);
        if (me.go) chk("mon_winner_right", int'(winner_right), int'(me.wr));
      end
    end
    prev_armed = armed;
  end

  task automatic wait_armed(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (armed) begin ok = 1; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL wait_armed actual=timeout expected=armed at %0t", $time);
    end
  endtask

  task automatic do_start(input bit check_timing);
    @(negedge clk);
    start = 1'b1; right = 1'($urandom); tie = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    model_reset();
    chk("start_pos", int'(pos), 0);
    chk("start_rounds", int'(rounds), 0);
    chk("start_game_over", int'(game_over), 0);
    chk("start_clr", int'(clr), 1);
    if (check_timing) begin
      for (int i = 0; i < AD - 1; i++) begin
        @(negedge clk);
        chk("arm_delay_clr", int'(clr), 1);
        chk("arm_delay_armed", int'(armed), 0);
      end
      @(negedge clk);
      chk("arm_armed", int'(armed), 1);
      chk("arm_clr", int'(clr), 0);
    end
  endtask

  task automatic play_round(input bit r, input bit t, input bit col, input bit noise);
    bit ok;
    wait_armed(ok);
    if (!ok) return;
    winrnd = 1'b1; right = r; tie = t; start = col;
    if (col) model_reset();
    else begin
      if (m_rounds < 255) m_rounds++;
      if (!t) m_pos += r ? 1 : -1;
      if (m_pos == WS || m_pos == -WS) begin m_over = 1; m_wr = (m_pos > 0); end
    end
    push_exp();
    @(negedge clk);
    winrnd = 1'b0; start = 1'b0; right = 1'($urandom); tie = 1'($urandom);
    if (noise) begin
      winrnd = 1'b1;
      @(negedge clk);
      winrnd = 1'b0;
    end
  endtask

  initial begin
    bit ok;
    int guard;
    repeat (2) @(negedge clk);
    chk("rst_clr", int'(clr), 1);
    chk("rst_armed", int'(armed), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_clr", int'(clr), 1);
    chk("idle_armed", int'(armed), 0);
    chk("idle_pos", int'(pos), 0);
    chk("idle_led", int'(led), 5'b00100);
    chk("idle_rounds", int'(rounds), 0);
    chk("idle_game_over", int'(game_over), 0);

    // Right player wins in two rounds; a later pulse is ignored in OVER.
    do_start(1);
    play_round(1, 0, 0, 0);
    play_round(1, 0, 0, 1);
    @(negedge clk);
    winrnd = 1'b1; right = 1'b0; tie = 1'b0;
    @(negedge clk);
    winrnd = 1'b0;
    @(negedge clk);
    chk("over_hold_pos", int'(pos), m_pos);
    chk("over_hold_rounds", int'(rounds), m_rounds);
    chk("over_hold_led", int'(led), 5'b10000);
    chk("over_hold_go", int'(game_over), 1);
    chk("over_hold_wr", int'(winner_right), 1);

    // Left, tie, right, left, left with a DELAY-time pulse after the tie.
    do_start(0);
    play_round(0, 0, 0, 0);
    play_round(0, 1, 0, 1);
    play_round(1, 0, 0, 0);
    play_round(0, 0, 0, 1);
    play_round(0, 0, 0, 0);

    // Start colliding with a round result in ARMED discards the round.
    do_start(0);
    play_round(1, 0, 0, 0);
    play_round(1, 0, 1, 0);
    play_round(0, 1, 0, 0);

    // Asynchronous reset while armed with pos=1.
    play_round(1, 0, 0, 0);
    wait_armed(ok);
    #2;
    rst = 1'b1;
    model_reset();
    push_exp();
    #1;
    chk("async_clr", int'(clr), 1);
    chk("async_armed", int'(armed), 0);
    chk("async_pos", int'(pos), 0);
    chk("async_rounds", int'(rounds), 0);
    chk("async_led", int'(led), 5'b00100);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle_clr", int'(clr), 1);
    chk("post_rst_idle_armed", int'(armed), 0);

    // Randomised matches.
    for (int m = 0; m < 6; m++) begin
      do_start(m == 0);
      guard = 0;
      while (!m_over && guard < 40) begin
        play_round(1'($urandom), ($urandom_range(3) == 0), ($urandom_range(9) == 0),
                   1'($urandom));
        guard++;
      end
      guard = 0;
      while (!m_over && guard < 10) begin
        play_round(1, 0, 0, 0);
        guard++;
      end
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
